// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and queues {pc, instr} for decode.
// Optional FETCH_STATS_EN adds saturating push and stall counters as output ports.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t state_q, state_d;

  logic [63:0]   pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   q_pc    [FQ_DEPTH];
  logic [31:0]   q_instr [FQ_DEPTH];
  logic [63:0]   last_pc;
  logic [31:0]   last_instr;
  logic          full, push, pop, flush;
  logic [63:0]   redirect_target;

  assign imem_pc         = pc;
  assign full            = (count == DEPTH_C);
  assign dec_valid       = (count != '0);
  assign redirect_target = redirect_pc & ~64'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // BOOT ignores memory data on the first edge; redirect outranks any pop.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        flush = redirect_valid;
        pop   = dec_valid && dec_ready && !redirect_valid;
        push  = !redirect_valid && (!full || pop);
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (push) begin
      pc <= pc + 64'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_instr;
    end
  end

  // Remembers the last presented head so the outputs hold while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc    <= '0;
      last_instr <= '0;
    end else if (dec_valid) begin
      last_pc    <= q_pc[rd_ptr];
      last_instr <= q_instr[rd_ptr];
    end
  end

  assign dec_pc    = dec_valid ? q_pc[rd_ptr]    : last_pc;
  assign dec_instr = dec_valid ? q_instr[rd_ptr] : last_instr;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (push && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
      if (state_q == RUN && full && !pop && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected {pc, instr} entries.
// Counter checks are compiled in when FETCH_STATS_EN is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] model_instr(input logic [63:0] pc);
    logic [61:0] idx;
    idx = pc[63:2];
    if (idx == 62'd0) return 32'h003202b3;
    if (idx == 62'd1) return 32'h00638433;
    return {8'hA5, idx[23:0]};
  endfunction

  assign imem_instr = model_instr(imem_pc);

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_stall     (stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected fetch stream from an aligned start address.
  task automatic load_sb(input logic [63:0] start);
    logic [63:0] a;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      a = start + 64'(4 * i);
      sb.push_back({a, model_instr(a)});
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [63:0] rpc);
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // Called with this cycle's inputs settled: predicts and scores an accepted pop.
  task automatic checkOutput();
    entry_t e;
    if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
      tests_run++;
      assert (sb.size() != 0) else begin
        tests_failed++;
        $error("[TB] FAIL sb_underflow observed=pop pc %h expected=no entry", dec_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_pc", dec_pc, e.pc);
        check("pop_instr", 64'(dec_instr), 64'(e.instr));
      end
    end
  endtask

  task automatic advance();
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 64'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc", dec_pc, 64'd0);
    check("rst_imem_pc", imem_pc, 64'd0);
`ifdef FETCH_STATS_EN
    check("rst_stat_fetched", 64'(stat_fetched), 64'd0);
    check("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif

    // Reset release: BOOT, then first head one cycle after the first RUN edge.
    rst_n = 1'b1;
    load_sb(64'h0);
    check("boot_dec_valid", 64'(dec_valid), 64'd0);
    advance();
    check("run0_dec_valid", 64'(dec_valid), 64'd0);
    check("run0_imem_pc", imem_pc, 64'd0);
    advance();
    check("first_valid", 64'(dec_valid), 64'd1);
    check("first_pc", dec_pc, 64'h0);
    check("first_instr", 64'(dec_instr), 64'h003202b3);
    check("first_imem_pc", imem_pc, 64'h4);
`ifdef FETCH_STATS_EN
    check("first_stat_fetched", 64'(stat_fetched), 64'd1);
`endif
    advance();
    check("second_pc", dec_pc, 64'h4);
    check("second_instr", 64'(dec_instr), 64'h00638433);
    advance();
    advance();

    // Stall from release: two pushes then the queue is full.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    load_sb(64'h0);
    for (int i = 0; i < 5; i++) advance();
    check("stall_valid", 64'(dec_valid), 64'd1);
    check("stall_head_pc", dec_pc, 64'h0);
    check("stall_imem_pc", imem_pc, 64'h8);
`ifdef FETCH_STATS_EN
    check("stall_stat_fetched", 64'(stat_fetched), 64'd2);
    check("stall_stat_stall", 64'(stat_stall), 64'd2);
`endif
    applyStimulus(1'b1, 1'b0, 64'h0);
    advance();
    check("drain1_pc", dec_pc, 64'h4);
    check("drain1_imem_pc", imem_pc, 64'hC);
    advance();
    check("drain2_valid", 64'(dec_valid), 64'd1);
    check("drain2_pc", dec_pc, 64'h8);
    check("drain2_imem_pc", imem_pc, 64'h10);

    // Full queue with continuous ready: one in, one out per cycle.
    for (int i = 0; i < 4; i++) begin
      advance();
      check("stream_pc", dec_pc, 64'(12 + 4 * i));
      check("stream_imem_pc", imem_pc, 64'(20 + 4 * i));
    end

    // Redirect with two entries queued and a concurrent ready.
    applyStimulus(1'b1, 1'b1, 64'h40);
    load_sb(64'h40);
    advance();
    applyStimulus(1'b1, 1'b0, 64'h0);
    check("redir_valid_gap", 64'(dec_valid), 64'd0);
    check("redir_imem_pc", imem_pc, 64'h40);
    advance();
    check("redir_head_valid", 64'(dec_valid), 64'd1);
    check("redir_head_pc", dec_pc, 64'h40);
    check("redir_head_instr", 64'(dec_instr), 64'(model_instr(64'h40)));
    advance();
    advance();

    // Misaligned target is forced to a word boundary.
    applyStimulus(1'b1, 1'b1, 64'h43);
    load_sb(64'h40);
    advance();
    applyStimulus(1'b1, 1'b0, 64'h0);
    check("align_imem_pc", imem_pc, 64'h40);
    check("align_valid_gap", 64'(dec_valid), 64'd0);
    advance();
    check("align_head_pc", dec_pc, 64'h40);
    advance();

    // PC wraps modulo 2^64.
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    load_sb(64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    applyStimulus(1'b1, 1'b0, 64'h0);
    check("wrap_imem_pc", imem_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    check("wrap_head_pc", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_imem_pc", imem_pc, 64'h0);
    advance();
    check("wrap_after_pc", dec_pc, 64'h0);
    check("wrap_after_instr", 64'(dec_instr), 64'h003202b3);

    // Asynchronous reset mid-stream once pc reaches 0x20.
    applyStimulus(1'b1, 1'b1, 64'h18);
    load_sb(64'h18);
    advance();
    applyStimulus(1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 8 && imem_pc !== 64'h20; i++) advance();
    check("midrst_reached_pc", imem_pc, 64'h20);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dec_valid", 64'(dec_valid), 64'd0);
    check("midrst_imem_pc", imem_pc, 64'h0);
    check("midrst_dec_pc", dec_pc, 64'h0);
`ifdef FETCH_STATS_EN
    check("midrst_stat_fetched", 64'(stat_fetched), 64'd0);
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_sb(64'h0);
    check("midrst_boot_valid", 64'(dec_valid), 64'd0);
    advance();
    check("midrst_run0_valid", 64'(dec_valid), 64'd0);
    check("midrst_run0_imem_pc", imem_pc, 64'h0);
    advance();
    check("midrst_head_valid", 64'(dec_valid), 64'd1);
    check("midrst_head_pc", dec_pc, 64'h0);
`ifdef FETCH_STATS_EN
    check("midrst_stat_fetched_1", 64'(stat_fetched), 64'd1);
`endif
    advance();

    // Redirect during BOOT loads the target while BOOT completes.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 64'h80);
    load_sb(64'h80);
    advance();
    applyStimulus(1'b1, 1'b0, 64'h0);
    check("bootredir_valid", 64'(dec_valid), 64'd0);
    check("bootredir_imem_pc", imem_pc, 64'h80);
    advance();
    check("bootredir_head_valid", 64'(dec_valid), 64'd1);
    check("bootredir_head_pc", dec_pc, 64'h80);
    advance();
    advance();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
